// File: rtl/matvec_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : matvec_mac_engine
// Purpose  : Signed matrix-vector multiplier C = A*B. LANES MAC lanes each
//            own one row of a block; blocks of LANES rows run back to back.
//            Operands come from 1-cycle-latency RAM ports; each finished block
//            is parked in a drain buffer and written out one row per cycle
//            while the next block accumulates.
// Revision : 1.0  initial release
// ============================================================================
module matvec_mac_engine #(
  parameter int DIM   = 8,
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW + $clog2(DIM),
  localparam int NB   = DIM / LANES,
  localparam int AAW  = (NB*DIM > 1) ? $clog2(NB*DIM) : 1,
  localparam int VAW  = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  a_rd_en,
  output logic [AAW-1:0]        a_rd_addr,
  input  logic [LANES*DW-1:0]   a_rd_data,
  output logic [VAW-1:0]        b_rd_addr,
  input  logic [DW-1:0]         b_rd_data,
  output logic                  c_we,
  output logic [VAW-1:0]        c_addr,
  output logic [ACC_W-1:0]      c_wdata
);

  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [AAW-1:0] C_A_LAST    = AAW'(NB*DIM - 1);
  localparam logic [VAW-1:0] C_K_LAST    = VAW'(DIM - 1);
  localparam logic [BW-1:0]  C_B_LAST    = BW'(NB - 1);
  localparam logic [IW-1:0]  C_DREM_INIT = IW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                    r_state;
  logic                      r_relu;

  // Read-data pipeline tag: which term k is arriving this cycle.
  logic                      r_v;
  logic [VAW-1:0]            r_vk;

  logic signed [ACC_W-1:0]   r_acc [LANES];
  logic signed [ACC_W-1:0]   r_buf [LANES];
  logic signed [ACC_W-1:0]   w_sum [LANES];

  logic [IW-1:0]             r_drem;   // rows still to write after the current one
  logic                      r_dlast;  // current drain belongs to the final block
  logic [BW-1:0]             r_cblk;   // blocks captured so far in this job

  logic signed [DW-1:0]      w_b;
  logic                      w_capture;
  logic                      w_drain_end;

  assign w_b         = b_rd_data;
  assign w_capture   = r_v && (r_vk == C_K_LAST);
  assign w_drain_end = c_we && (r_drem == '0) && r_dlast;

  // Negative results clamp to zero when the job was started in ReLU mode.
  function automatic logic [ACC_W-1:0] relu_fn(input logic en, input logic signed [ACC_W-1:0] v);
    return (en && v[ACC_W-1]) ? '0 : v;
  endfunction

  // Per-lane product and next accumulator value; term k=0 loads instead of adding.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [DW-1:0]     w_a;
    logic signed [2*DW-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    assign w_a        = a_rd_data[gi*DW +: DW];
    assign w_prod     = (2*DW)'(w_a) * (2*DW)'(w_b);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_sum[gi]  = (r_vk == '0) ? w_prod_ext : r_acc[gi] + w_prod_ext;
  end

  // Control FSM: issues one A/B read per cycle, then waits for the last drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_relu    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_rd_en   <= 1'b0;
      a_rd_addr <= '0;
      b_rd_addr <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_relu    <= relu_en;
            busy      <= 1'b1;
            a_rd_en   <= 1'b1;
            a_rd_addr <= '0;
            b_rd_addr <= '0;
          end
        end
        S_RUN: begin
          // blk*DIM+k advances by exactly one per issue, so the A address is a plain counter.
          if (a_rd_addr == C_A_LAST) begin
            a_rd_en <= 1'b0;
            r_state <= S_FLUSH;
          end else begin
            a_rd_addr <= a_rd_addr + 1'b1;
            b_rd_addr <= (b_rd_addr == C_K_LAST) ? '0 : b_rd_addr + 1'b1;
          end
        end
        S_FLUSH: begin
          if (w_drain_end) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Track which term the read data arriving next cycle belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v  <= 1'b0;
      r_vk <= '0;
    end else begin
      r_v  <= a_rd_en;
      r_vk <= b_rd_addr;
    end
  end

  // Lane accumulators update whenever valid read data is present.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
    end else if (r_v) begin
      for (int i = 0; i < LANES; i++) r_acc[i] <= w_sum[i];
    end
  end

  // Drain buffer: row 0 goes straight out at capture, the rest shift out one per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_we    <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
      r_drem  <= '0;
      r_dlast <= 1'b0;
      r_cblk  <= '0;
      for (int i = 0; i < LANES; i++) r_buf[i] <= '0;
    end else if (w_capture) begin
      c_we    <= 1'b1;
      c_addr  <= (r_cblk == '0) ? '0 : c_addr + 1'b1;
      c_wdata <= relu_fn(r_relu, w_sum[0]);
      r_drem  <= C_DREM_INIT;
      r_dlast <= (r_cblk == C_B_LAST);
      r_cblk  <= r_cblk + 1'b1;
      for (int i = 0; i < LANES - 1; i++) r_buf[i] <= w_sum[i+1];
      r_buf[LANES-1] <= '0;
    end else begin
      if (c_we) begin
        if (r_drem == '0) begin
          c_we <= 1'b0;
        end else begin
          c_addr  <= c_addr + 1'b1;
          c_wdata <= relu_fn(r_relu, r_buf[0]);
          r_drem  <= r_drem - 1'b1;
          for (int i = 0; i < LANES - 1; i++) r_buf[i] <= r_buf[i+1];
          r_buf[LANES-1] <= '0;
        end
      end
      if (r_state == S_IDLE && start) r_cblk <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matvec_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_matvec_mac_engine
// Purpose  : Self-checking bench. Runs an 8-lane and a 4-lane engine (DIM=8)
//            side by side on the same operands and checks every cycle of each
//            job against a plain-arithmetic reference and the documented timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_matvec_mac_engine;

  logic clk = 1'b0;
  logic reset, start, relu_en;

  logic        busy8, done8, a_en8, c_we8;
  logic [5:0]  a_addr8;
  logic [63:0] a_data8;
  logic [2:0]  b_addr8, c_addr8;
  logic [7:0]  b_data8;
  logic [18:0] c_wdata8;

  logic        busy4, done4, a_en4, c_we4;
  logic [3:0]  a_addr4;
  logic [31:0] a_data4;
  logic [2:0]  b_addr4, c_addr4;
  logic [7:0]  b_data4;
  logic [18:0] c_wdata4;

  logic signed [7:0] A [8][8];
  logic signed [7:0] B [8];
  int expC [8];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  matvec_mac_engine #(.DIM(8), .LANES(8), .DW(8), .ACC_W(19)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy8), .done(done8), .a_rd_en(a_en8), .a_rd_addr(a_addr8),
    .a_rd_data(a_data8), .b_rd_addr(b_addr8), .b_rd_data(b_data8),
    .c_we(c_we8), .c_addr(c_addr8), .c_wdata(c_wdata8)
  );

  matvec_mac_engine #(.DIM(8), .LANES(4), .DW(8), .ACC_W(19)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy4), .done(done4), .a_rd_en(a_en4), .a_rd_addr(a_addr4),
    .a_rd_data(a_data4), .b_rd_addr(b_addr4), .b_rd_data(b_data4),
    .c_we(c_we4), .c_addr(c_addr4), .c_wdata(c_wdata4)
  );

  // Synchronous operand RAMs, one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      a_data8[i*8 +: 8] <= A[(int'(a_addr8) / 8) * 8 + i][int'(a_addr8) % 8];
    for (int j = 0; j < 4; j++)
      a_data4[j*8 +: 8] <= A[(int'(a_addr4) / 8) * 4 + j][int'(a_addr4) % 8];
    b_data8 <= B[b_addr8];
    b_data4 <= B[b_addr4];
  end

  function automatic int wrap19(input int v);
    logic signed [18:0] t;
    t = v[18:0];
    return int'(t);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Expected behaviour of one engine with L lanes in cycle t of a job.
  task automatic check_cycle(input string nm, input int L, input int t, input bit ab,
                             input logic bsy, input logic dn, input logic aen,
                             input logic [31:0] aaddr, input logic [31:0] baddr,
                             input logic cwe, input logic [31:0] caddr,
                             input logic signed [31:0] cdata);
    int nb, row;
    bit busy_e, done_e, aen_e;
    nb     = 8 / L;
    busy_e = !ab && (t <= nb*8 + L);
    done_e = !ab && (t == nb*8 + L + 1);
    aen_e  = !ab && (t <= nb*8 - 1);
    row    = -1;
    if (!ab)
      for (int b = 0; b < nb; b++)
        if (t >= (b+1)*8 + 1 && t <= (b+1)*8 + L) row = b*L + t - (b+1)*8 - 1;
    chk($sformatf("%s_busy_c%0d", nm, t), bsy, busy_e);
    chk($sformatf("%s_done_c%0d", nm, t), dn, done_e);
    chk($sformatf("%s_a_rd_en_c%0d", nm, t), aen, aen_e);
    chk($sformatf("%s_c_we_c%0d", nm, t), cwe, row >= 0);
    if (aen_e) begin
      chk($sformatf("%s_a_rd_addr_c%0d", nm, t), aaddr, t);
      chk($sformatf("%s_b_rd_addr_c%0d", nm, t), baddr, t % 8);
    end
    if (row >= 0) begin
      chk($sformatf("%s_c_addr_c%0d", nm, t), caddr, row);
      chk($sformatf("%s_c_wdata_r%0d", nm, row), cdata, expC[row]);
    end
  endtask

  // One job on both engines; rst_at >= 0 asserts reset during that cycle.
  // start is pulsed in cycles 3 and 10 and relu_en toggled randomly throughout;
  // neither may disturb the running job.
  task automatic run_job(input bit relu, input int rst_at);
    for (int r = 0; r < 8; r++) begin
      int s = 0;
      for (int c = 0; c < 8; c++) s += int'(A[r][c]) * int'(B[c]);
      expC[r] = wrap19(s);
      if (relu && expC[r] < 0) expC[r] = 0;
    end
    start   = 1'b1;
    relu_en = relu;
    @(posedge clk);
    for (int t = 0; t <= 23; t++) begin
      bit ab;
      @(negedge clk);
      ab = (rst_at >= 0) && (t > rst_at);
      check_cycle("L8", 8, t, ab, busy8, done8, a_en8, 32'(a_addr8), 32'(b_addr8),
                  c_we8, 32'(c_addr8), 32'($signed(c_wdata8)));
      check_cycle("L4", 4, t, ab, busy4, done4, a_en4, 32'(a_addr4), 32'(b_addr4),
                  c_we4, 32'(c_addr4), 32'($signed(c_wdata4)));
      start   = (t == 3 || t == 10);
      relu_en = 1'($urandom_range(0, 1));
      if (t == rst_at) reset = 1'b1;
      else if (t == rst_at + 1) reset = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic rand_ops();
    for (int r = 0; r < 8; r++) begin
      B[r] = 8'($urandom_range(0, 255));
      for (int c = 0; c < 8; c++) A[r][c] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    relu_en = 1'b0;
    for (int r = 0; r < 8; r++) begin
      B[r] = '0;
      for (int c = 0; c < 8; c++) A[r][c] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy8", busy8, 0);     chk("rst_busy4", busy4, 0);
    chk("rst_done8", done8, 0);     chk("rst_done4", done4, 0);
    chk("rst_a_en8", a_en8, 0);     chk("rst_a_en4", a_en4, 0);
    chk("rst_c_we8", c_we8, 0);     chk("rst_c_we4", c_we4, 0);
    chk("rst_a_addr8", 32'(a_addr8), 0); chk("rst_a_addr4", 32'(a_addr4), 0);
    chk("rst_b_addr8", 32'(b_addr8), 0); chk("rst_b_addr4", 32'(b_addr4), 0);
    chk("rst_c_addr8", 32'(c_addr8), 0); chk("rst_c_addr4", 32'(c_addr4), 0);
    chk("rst_c_wdata8", 32'(c_wdata8), 0); chk("rst_c_wdata4", 32'(c_wdata4), 0);
    reset = 1'b0;

    // Identity times 1..8
    for (int r = 0; r < 8; r++) begin
      B[r] = 8'(r + 1);
      for (int c = 0; c < 8; c++) A[r][c] = (r == c) ? 8'sd1 : 8'sd0;
    end
    run_job(1'b0, -1);

    // Most-negative operands: 8 * 16384 = 131072
    for (int r = 0; r < 8; r++) begin
      B[r] = -8'sd128;
      for (int c = 0; c < 8; c++) A[r][c] = -8'sd128;
    end
    run_job(1'b0, -1);

    // 127 * -128 * 8 = -130048
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) A[r][c] = 8'sd127;
    run_job(1'b0, -1);

    // A[r][c] = r+c, B all 1: rows 28,36,...,84
    for (int r = 0; r < 8; r++) begin
      B[r] = 8'sd1;
      for (int c = 0; c < 8; c++) A[r][c] = 8'(r + c);
    end
    run_job(1'b0, -1);

    // ReLU with negated identity: every write is 0
    for (int r = 0; r < 8; r++) begin
      B[r] = 8'(r + 1);
      for (int c = 0; c < 8; c++) A[r][c] = (r == c) ? -8'sd1 : 8'sd0;
    end
    run_job(1'b1, -1);

    // Reset during cycle 12 abandons the job; the next job must be clean
    rand_ops();
    run_job(1'b0, 12);
    rand_ops();
    run_job(1'b0, -1);

    // Random operands, random ReLU mode
    for (int n = 0; n < 4; n++) begin
      rand_ops();
      run_job(1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matvec_mac_engine.md
# matvec_mac_engine

- Parametrised signed matrix-vector multiplier: computes C = A·B for a DIM×DIM matrix A and a DIM-element vector B.
- LANES parallel MAC lanes each compute one row; rows are processed in DIM/LANES blocks back to back.
- Sits between the A/B operand RAMs and the C result RAM. Reads use synchronous 1-cycle-latency memory ports; results are written serially through a drain buffer.
- Adds configurable lane count, matrix size and data width, a start/busy/done handshake, a ReLU output mode, and overlap of result write-back with computation of the next block.

## Interface

Parameters:
- DIM, 8: matrix/vector dimension; must be a multiple of LANES.
- LANES, 8: number of parallel MAC lanes; 1 ≤ LANES ≤ DIM.
- DW, 8: signed operand width.
- ACC_W, 2*DW+$clog2(DIM): signed accumulator/result width (19 at defaults).
- Derived: NB = DIM/LANES; AAW = $clog2(NB*DIM); VAW = $clog2(DIM), minimum 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- relu_en  in  1  clamp negative results to 0; latched when start is accepted.
- busy  out  1  high while a job is in progress.
- done  out  1  single-cycle completion pulse.
- a_rd_en  out  1  A read strobe.
- a_rd_addr  out  AAW  A word address = blk*DIM + k.
- a_rd_data  in  LANES*DW  packed A word; lane i in bits [i*DW +: DW] = A[blk*LANES+i][k]. Valid 1 cycle after the address.
- b_rd_addr  out  VAW  B element index k.
- b_rd_data  in  DW  B[k]; valid 1 cycle after the address.
- c_we  out  1  C write strobe.
- c_addr  out  VAW  C row index.
- c_wdata  out  ACC_W  result value.

## Operation

- States: IDLE, RUN, FLUSH.
- IDLE → RUN: on start=1. Latch relu_en; set blk=0, k=0.
- RUN:
  - Each cycle, issue a_rd_en=1 with a_rd_addr=blk*DIM+k and b_rd_addr=k.
  - Then k++; when k wraps from DIM-1 to 0, blk++.
  - After the last issue (blk=NB-1, k=DIM-1), go to FLUSH.
- Lanes (data valid 1 cycle after issue):
  - prod_i = a_i × b, computed as a 2*DW signed product and sign-extended to ACC_W.
  - For k=0, acc_i loads prod_i; this replaces a separate clear cycle.
  - Otherwise acc_i += prod_i. Arithmetic wraps modulo 2^ACC_W.
- Drain buffer:
  - At the edge that accumulates the k=DIM-1 term, buf_i captures acc_i+prod_i.
  - On the following LANES cycles, write c_we=1, c_addr=blk*LANES+i, c_wdata=buf_i, for i=0..LANES-1 in order.
  - With relu_en latched and buf_i<0, c_wdata=0.
  - Draining overlaps the next block's accumulation. LANES≤DIM guarantees buf is emptied before its next capture.
- FLUSH: wait for the final block's accumulation and drain to finish, then go to IDLE and pulse done.
- start while busy: ignored, with no effect on the job in progress.
- reset at any time:
  - State returns to IDLE; all outputs go to 0.
  - No further c_we pulses; a partial job is abandoned with no done pulse.

## Timing

- Cycle 0 is the first cycle after the edge that accepted start.
- Term k of block b:
  - Issued in cycle b*DIM+k.
  - Data valid in cycle b*DIM+k+1.
  - Accumulated at the end of cycle b*DIM+k+1.
- Block b's buffer captures at the end of cycle (b+1)*DIM.
- c_we is high in cycles (b+1)*DIM+1 … (b+1)*DIM+LANES.
- busy is high in cycles 0 … NB*DIM+LANES.
- done is high in cycle NB*DIM+LANES+1, the first IDLE cycle.
  - Defaults: writes in cycles 9–16, done in cycle 17.
  - DIM=8, LANES=4: writes in cycles 9–12 and 17–20, done in cycle 21.
- start=1 in the done cycle is accepted; that cycle becomes the previous job's last cycle before the new cycle 0.
- a_rd_en is high in cycles 0 … NB*DIM-1, continuous with no bubbles.
- Reset values: busy, done, a_rd_en, c_we = 0; a_rd_addr, b_rd_addr, c_addr = 0; c_wdata = 0.
- Addresses hold their last value when not strobed.

## Test plan

- Defaults, A=identity, B=1..8 → c_addr 0..7 receives 1..8 in cycles 9–16; done in cycle 17 only; busy high in cycles 0–16.
- Defaults, all A=-128 and all B=-128 → every result is 131072 with no overflow. Then all A=127, B=-128 → every result is -130048.
- DIM=8, LANES=4, A[r][c]=r+c, B all 1 → rows 0–3 = 28,36,44,52 in cycles 9–12; rows 4–7 = 60,68,76,84 in cycles 17–20; done in cycle 21.
- relu_en=1 with A=-identity, B=1..8 → all eight writes carry 0. relu_en toggled mid-job has no effect.
- start pulsed in cycles 3 and 10 of a running job → ignored; exactly 8 writes and 1 done.
- Reset asserted in cycle 12 → from the next cycle, busy=0 and c_we=0 with no done. A new start then completes a correct full job.
